// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: AXI4-lite bus between uart_tx_queue and a UART-lite slave.
//   master modport: the queue (drives addresses, valids, wdata, rready/bready)
//   slave  modport: the UART side (drives readies, rdata/rresp, bresp/bvalid)
interface uart_tx_queue_if;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffered UART transmit engine.
// The core pushes 1..PUSH_BYTES bytes per request into a byte FIFO; the block
// drains it one byte per round over AXI4-lite: poll STAT_REG (0x8) until the
// UART TX FIFO is not full (rdata[3]==0), then write the head byte to TX_FIFO
// (0x4) and wait for the write response before popping it.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   push_data/count/valid enqueue request, byte 0 = push_data[7:0] goes first
//   push_ready            registered: free entries >= PUSH_BYTES
//   level                 bytes currently queued
//   idle                  queue empty and bus engine idle
//   err / err_clr         sticky bus-error flag and its clear
//   uart_axi              AXI4-lite master port to the UART-lite
module uart_tx_queue #(
    parameter int DEPTH      = 16,
    parameter int PUSH_BYTES = 4,
    parameter int POLL_GAP   = 0
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [8*PUSH_BYTES-1:0]         push_data,
    input  logic [$clog2(PUSH_BYTES+1)-1:0] push_count,
    input  logic                            push_valid,
    output logic                            push_ready,
    output logic [$clog2(DEPTH+1)-1:0]      level,
    output logic                            idle,
    output logic                            err,
    input  logic                            err_clr,
    uart_tx_queue_if.master                 uart_axi
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(PUSH_BYTES + 1);
    // gap counter runs 0..POLL_GAP-1
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic [LW-1:0] push_add_s;
    logic [GW-1:0] gap_cnt_r;
    logic          push_fire_s;
    logic          pop_s;
    logic          err_set_s;
    logic          aw_done_s;
    logic          w_done_s;
    logic          poll_full_s;
    logic          enter_w_s;
    logic          arvalid_r;
    logic          rready_r;
    logic          awvalid_r;
    logic          wvalid_r;
    logic          bready_r;
    logic [7:0]    wdata_r;
    logic          err_r;
    logic          push_ready_r;
    logic          idle_r;
    logic          unused_s;

    // Push/pop qualification and the occupancy after this edge
    always_comb begin
        push_fire_s = push_valid && push_ready_r;
        pop_s       = (state_r == S_B) && bready_r && uart_axi.bvalid;
        if (push_fire_s) begin
            push_add_s = LW'(push_count);
        end else begin
            push_add_s = {LW{1'b0}};
        end
        if (pop_s) begin
            level_nxt_s = level_r + push_add_s - LW'(1'b1);
        end else begin
            level_nxt_s = level_r + push_add_s;
        end
    end

    // Bus engine next-state and error detection
    always_comb begin
        state_nxt_s = state_r;
        err_set_s   = 1'b0;
        // a valid already dropped means that half of the write is done
        aw_done_s   = !awvalid_r || uart_axi.awready;
        w_done_s    = !wvalid_r || uart_axi.wready;
        // an errored status read cannot be trusted, so treat it as full
        poll_full_s = uart_axi.rdata[3] || (uart_axi.rresp != 2'b00);
        case (state_r)
            S_IDLE: begin
                if (level_r != {LW{1'b0}}) begin
                    state_nxt_s = S_AR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_AR: begin
                if (arvalid_r && uart_axi.arready) begin
                    state_nxt_s = S_R;
                end else begin
                    state_nxt_s = S_AR;
                end
            end
            S_R: begin
                if (rready_r && uart_axi.rvalid) begin
                    err_set_s = (uart_axi.rresp != 2'b00);
                    if (!poll_full_s) begin
                        state_nxt_s = S_W;
                    end else if (POLL_GAP == 0) begin
                        state_nxt_s = S_AR;
                    end else begin
                        state_nxt_s = S_GAP;
                    end
                end else begin
                    state_nxt_s = S_R;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == GW'(POLL_GAP - 1)) begin
                    state_nxt_s = S_AR;
                end else begin
                    state_nxt_s = S_GAP;
                end
            end
            S_W: begin
                if (aw_done_s && w_done_s) begin
                    state_nxt_s = S_B;
                end else begin
                    state_nxt_s = S_W;
                end
            end
            S_B: begin
                if (pop_s) begin
                    // the byte is popped even on a bad response and is lost
                    err_set_s = (uart_axi.bresp != 2'b00);
                    if (level_nxt_s != {LW{1'b0}}) begin
                        state_nxt_s = S_AR;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_B;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        enter_w_s = (state_r != S_W) && (state_nxt_s == S_W);
    end

    // FIFO storage: only written, no reset needed since level gates reads
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_BYTES; i++) begin
            if (push_fire_s && (CW'(i) < push_count)) begin
                mem_r[wr_ptr_r + AW'(i)] <= push_data[8*i +: 8];
            end
        end
    end

    // Queue pointers, occupancy and status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            push_ready_r <= 1'b1;
            idle_r       <= 1'b1;
            err_r        <= 1'b0;
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(push_count);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r      <= level_nxt_s;
            // registered off next level so push_ready never sees push_* combinationally
            push_ready_r <= (level_nxt_s <= LW'(DEPTH - PUSH_BYTES));
            idle_r       <= (level_nxt_s == {LW{1'b0}}) && (state_nxt_s == S_IDLE);
            // a new error wins over a clear in the same cycle
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Bus engine state and registered AXI handshake outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            gap_cnt_r <= {GW{1'b0}};
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            wdata_r   <= 8'h00;
        end else begin
            state_r   <= state_nxt_s;
            arvalid_r <= (state_nxt_s == S_AR);
            rready_r  <= (state_nxt_s == S_R);
            bready_r  <= (state_nxt_s == S_B);
            if ((state_r == S_GAP) && (state_nxt_s == S_GAP)) begin
                gap_cnt_r <= gap_cnt_r + GW'(1'b1);
            end else begin
                gap_cnt_r <= {GW{1'b0}};
            end
            // both write valids rise together, then each falls on its own ready
            if (enter_w_s) begin
                awvalid_r <= 1'b1;
            end else if (awvalid_r && uart_axi.awready) begin
                awvalid_r <= 1'b0;
            end else begin
                awvalid_r <= awvalid_r;
            end
            if (enter_w_s) begin
                wvalid_r <= 1'b1;
            end else if (wvalid_r && uart_axi.wready) begin
                wvalid_r <= 1'b0;
            end else begin
                wvalid_r <= wvalid_r;
            end
            // head is captured once; later pushes cannot move rd_ptr
            if (enter_w_s) begin
                wdata_r <= mem_r[rd_ptr_r];
            end else begin
                wdata_r <= wdata_r;
            end
        end
    end

    assign unused_s = ^{uart_axi.rdata[31:4], uart_axi.rdata[2:0]};

    assign uart_axi.araddr  = 4'h8;
    assign uart_axi.arvalid = arvalid_r;
    assign uart_axi.rready  = rready_r;
    assign uart_axi.awaddr  = 4'h4;
    assign uart_axi.awvalid = awvalid_r;
    assign uart_axi.wdata   = {24'h000000, wdata_r};
    assign uart_axi.wstrb   = 4'b0001;
    assign uart_axi.wvalid  = wvalid_r;
    assign uart_axi.bready  = bready_r;

    assign push_ready = push_ready_r;
    assign level      = level_r;
    assign idle       = idle_r;
    assign err        = err_r;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a behavioural UART-lite slave records every write,
// and each test compares the recorded byte stream and counters against a
// queue of bytes the bench itself pushed.
module tb_uart_tx_queue;
    localparam int DEPTH      = 16;
    localparam int PUSH_BYTES = 4;
    localparam int POLL_GAP   = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] push_data = 32'h0;
    logic [2:0]  push_count = 3'd0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [4:0]  level;
    logic        idle;
    logic        err;
    logic        err_clr = 1'b0;

    uart_tx_queue_if bus ();

    uart_tx_queue #(.DEPTH(DEPTH), .PUSH_BYTES(PUSH_BYTES), .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .rstn(rstn), .push_data(push_data), .push_count(push_count),
        .push_valid(push_valid), .push_ready(push_ready), .level(level), .idle(idle),
        .err(err), .err_clr(err_clr), .uart_axi(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model and slave observations
    logic [7:0]  exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] status_q[$];
    int ar_t[$];
    int r_t[$];
    int n_reads, n_writes, wr_full_viol, b_early_viol, bad_field, cyc;
    bit ar_stall, b_hold, bresp_err_once;
    int aw_delay;

    // slave-internal state
    bit s_ar_p, s_r_p, s_aw_p, s_w_p, s_b_p, s_aw_done, s_w_done, s_last_full;
    int s_aw_cnt;
    logic [31:0] s_w_cap;
    logic [3:0]  s_aw_cap;

    always @(posedge clk) begin
        if (push_valid) assert (push_count <= 3'd4) else $error("illegal push_count %0d", push_count);
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: run did not finish, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    // Behavioural UART-lite slave; acts on negedges, handshakes complete on posedges.
    initial begin : slave
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                bus.arready = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0;
                bus.wready = 1'b0; bus.bvalid = 1'b0;
                s_ar_p = 0; s_r_p = 0; s_aw_p = 0; s_w_p = 0; s_b_p = 0;
                s_aw_done = 0; s_w_done = 0; s_last_full = 0; s_aw_cnt = 0;
                continue;
            end
            if (s_b_p) begin
                bus.bvalid = 1'b0; n_writes++; s_aw_done = 0; s_w_done = 0;
            end
            if (s_r_p) begin
                bus.rvalid = 1'b0; n_reads++; r_t.push_back(cyc); s_last_full = bus.rdata[3];
            end
            if (s_ar_p) begin
                ar_t.push_back(cyc);
                bus.rdata = (status_q.size() > 0) ? status_q.pop_front() : 32'h0;
                bus.rresp = 2'b00;
                bus.rvalid = 1'b1;
            end
            if (s_w_p) begin
                obs_q.push_back(s_w_cap);
                if (s_last_full) wr_full_viol++;
                s_w_done = 1;
            end
            if (s_aw_p) begin
                if (s_aw_cap !== 4'h4) bad_field++;
                s_aw_done = 1; s_aw_cnt = 0;
            end
            if (s_aw_done && s_w_done && !bus.bvalid && !b_hold) begin
                bus.bvalid = 1'b1;
                bus.bresp = bresp_err_once ? 2'b10 : 2'b00;
                bresp_err_once = 0;
            end
            if (bus.bready && !(s_aw_done && s_w_done)) b_early_viol++;
            bus.arready = !ar_stall;
            bus.wready = bus.wvalid;
            if (bus.awvalid && !s_aw_done) begin
                s_aw_cnt++;
                bus.awready = (s_aw_cnt > aw_delay);
            end else begin
                bus.awready = 1'b0;
            end
            s_ar_p = bus.arvalid && bus.arready;
            if (s_ar_p && bus.araddr !== 4'h8) bad_field++;
            s_r_p = bus.rvalid && bus.rready;
            s_aw_p = bus.awvalid && bus.awready;
            s_aw_cap = bus.awaddr;
            s_w_p = bus.wvalid && bus.wready;
            s_w_cap = bus.wdata;
            if (s_w_p && bus.wstrb !== 4'b0001) bad_field++;
            s_b_p = bus.bvalid && bus.bready;
        end
    end

    task automatic clear_stats();
        exp_q.delete(); obs_q.delete(); status_q.delete(); ar_t.delete(); r_t.delete();
        n_reads = 0; n_writes = 0; wr_full_viol = 0; b_early_viol = 0; bad_field = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] d, input int c, output bit ok);
        int n = 0;
        push_data = d; push_count = 3'(c); push_valid = 1'b1;
        while (push_ready !== 1'b1 && n < 500) begin tick(); n++; end
        ok = (push_ready === 1'b1);
        if (ok) for (int i = 0; i < c; i++) exp_q.push_back(d[8*i +: 8]);
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        ok = 0;
        while (n < 3000) begin
            tick();
            if (idle === 1'b1 && level === 5'd0 && bus.bvalid === 1'b0) begin ok = 1; break; end
            n++;
        end
    endtask

    task automatic test_reset();
        tests++; if (push_ready !== 1'b1) begin fails++; $display("FAIL reset_push_ready got %b want 1", push_ready); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b want 1", idle); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++;
        if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin
            fails++; $display("FAIL reset_valids got %b want 00000",
                {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready});
        end
    endtask

    task automatic test_single();
        bit ok;
        clear_stats();
        do_push(32'h00000041, 1, ok);
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL single_level got %0d want 1", level); end
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_drain got timeout want idle"); end
        tests++; if (n_reads != 1 || n_writes != 1) begin fails++; $display("FAIL single_counts got r=%0d w=%0d want r=1 w=1", n_reads, n_writes); end
        tests++; if (obs_q.size() != 1 || obs_q[0] !== 32'h00000041) begin fails++; $display("FAIL single_wdata got n=%0d want one 0x41", obs_q.size()); end
        tests++; if (bad_field != 0) begin fails++; $display("FAIL single_fields got %0d bad addr/strb want 0", bad_field); end
    endtask

    task automatic test_burst4();
        bit ok;
        int c;
        clear_stats();
        do_push(32'h44434241, 4, ok);
        c = $urandom_range(1, 4);
        do_push($urandom, c, ok);
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL burst_drain got timeout want idle"); end
        tests++; if (n_reads != 4 + c || n_writes != 4 + c) begin fails++; $display("FAIL burst_counts got r=%0d w=%0d want %0d", n_reads, n_writes, 4 + c); end
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL burst_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== {24'h0, exp_q[i]}) begin fails++; $display("FAIL burst_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_poll_gap();
        bit ok;
        clear_stats();
        status_q = '{32'h8, 32'h8, 32'h8, 32'h0};
        do_push($urandom, 1, ok);
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL gap_drain got timeout want idle"); end
        tests++; if (n_reads != 4 || n_writes != 1) begin fails++; $display("FAIL gap_counts got r=%0d w=%0d want r=4 w=1", n_reads, n_writes); end
        tests++; if (wr_full_viol != 0) begin fails++; $display("FAIL gap_write_while_full got %0d want 0", wr_full_viol); end
        // full status -> POLL_GAP idle cycles, then one cycle for the address handshake
        for (int i = 0; i < 3 && i + 1 < ar_t.size() && i < r_t.size(); i++) begin
            tests++;
            if (ar_t[i+1] - r_t[i] != POLL_GAP + 1) begin
                fails++; $display("FAIL gap_spacing%0d got %0d want %0d", i, ar_t[i+1] - r_t[i], POLL_GAP + 1);
            end
        end
        tests++; if (obs_q.size() != 1 || obs_q[0] !== {24'h0, exp_q[0]}) begin fails++; $display("FAIL gap_wdata got n=%0d want %h", obs_q.size(), exp_q[0]); end
    endtask

    task automatic test_fill();
        bit ok;
        int mlevel = 0;
        clear_stats();
        ar_stall = 1;
        for (int k = 0; k < 4; k++) begin
            do_push($urandom, 4, ok);
            mlevel += 4;
            tests++; if (level !== 5'(mlevel)) begin fails++; $display("FAIL fill_level%0d got %0d want %0d", k, level, mlevel); end
            tests++;
            if (push_ready !== (mlevel <= DEPTH - PUSH_BYTES)) begin
                fails++; $display("FAIL fill_ready%0d got %b want %b", k, push_ready, mlevel <= DEPTH - PUSH_BYTES);
            end
        end
        push_data = $urandom; push_count = 3'd4; push_valid = 1'b1;
        repeat (3) tick();
        push_valid = 1'b0;
        tests++; if (level !== 5'd16) begin fails++; $display("FAIL fill_saturate got %0d want 16", level); end
        ar_stall = 0;
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL fill_drain got timeout want idle"); end
        tests++; if (obs_q.size() != 16) begin fails++; $display("FAIL fill_len got %0d want 16", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== {24'h0, exp_q[i]}) begin fails++; $display("FAIL fill_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_push_pop();
        bit ok;
        int n = 0;
        logic [31:0] d;
        clear_stats();
        ar_stall = 1; b_hold = 1; aw_delay = 3;
        do_push($urandom, 4, ok);
        do_push($urandom, 1, ok);
        tests++; if (level !== 5'd5) begin fails++; $display("FAIL pp_level5 got %0d want 5", level); end
        ar_stall = 0;
        while (bus.bready !== 1'b1 && n < 200) begin tick(); n++; end
        tests++; if (bus.bready !== 1'b1 || level !== 5'd5) begin fails++; $display("FAIL pp_reach_b got bready=%b level=%0d want 1/5", bus.bready, level); end
        b_hold = 0;
        tick();
        d = $urandom;
        push_data = d; push_count = 3'd3; push_valid = 1'b1;
        tests++; if (push_ready !== 1'b1 || bus.bvalid !== 1'b1) begin fails++; $display("FAIL pp_align got ready=%b bvalid=%b want 1/1", push_ready, bus.bvalid); end
        for (int i = 0; i < 3; i++) exp_q.push_back(d[8*i +: 8]);
        tick();
        push_valid = 1'b0;
        tests++; if (level !== 5'd7) begin fails++; $display("FAIL pp_level7 got %0d want 7", level); end
        wait_idle(ok);
        aw_delay = 0;
        tests++; if (!ok) begin fails++; $display("FAIL pp_drain got timeout want idle"); end
        tests++; if (b_early_viol != 0) begin fails++; $display("FAIL pp_b_early got %0d want 0", b_early_viol); end
        tests++; if (obs_q.size() != 8) begin fails++; $display("FAIL pp_len got %0d want 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== {24'h0, exp_q[i]}) begin fails++; $display("FAIL pp_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_err();
        bit ok;
        clear_stats();
        bresp_err_once = 1;
        do_push($urandom, 2, ok);
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL err_drain got timeout want idle"); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got %b want 1", err); end
        tests++; if (n_writes != 2 || obs_q.size() != 2) begin fails++; $display("FAIL err_writes got %0d want 2", n_writes); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== {24'h0, exp_q[i]}) begin fails++; $display("FAIL err_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        tick();
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b want 1", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        int c;
        clear_stats();
        aw_delay = 5;
        do_push($urandom, 3, ok);
        while (bus.awvalid !== 1'b1 && n < 200) begin tick(); n++; end
        tests++; if (bus.awvalid !== 1'b1) begin fails++; $display("FAIL rst_reach_w got awvalid=%b want 1", bus.awvalid); end
        rstn = 1'b0;
        #1;
        tests++; if ({bus.awvalid, bus.wvalid} !== 2'b00) begin fails++; $display("FAIL rst_valids got %b want 00", {bus.awvalid, bus.wvalid}); end
        tests++; if (level !== 5'd0 || push_ready !== 1'b1) begin fails++; $display("FAIL rst_level got %0d ready=%b want 0/1", level, push_ready); end
        tick();
        tick();
        rstn = 1'b1;
        aw_delay = 0;
        clear_stats();
        tick();
        c = $urandom_range(1, 4);
        do_push($urandom, c, ok);
        wait_idle(ok);
        tests++; if (!ok || obs_q.size() != c) begin fails++; $display("FAIL rst_recover got n=%0d want %0d", obs_q.size(), c); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++; if (obs_q[i] !== {24'h0, exp_q[i]}) begin fails++; $display("FAIL rst_byte%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        ar_stall = 0; b_hold = 0; bresp_err_once = 0; aw_delay = 0; cyc = 0;
        clear_stats();
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        test_reset();
        test_single();
        test_burst4();
        test_poll_gap();
        test_fill();
        test_push_pop();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
